// File: rtl/fphub_seq_multiplier_if.sv
// Issue/result bus of the HUB sequential multiplier.
// The operand layout and the start/finish/computing handshake are the same as
// the HUB SRT divider's, so FPU control can drive either unit.
interface fphub_seq_multiplier_if #(
   parameter int M = 23,
   parameter int E = 8
);
   localparam int W = M + E + 1;

   logic         start;
   logic [W-1:0] x;
   logic [W-1:0] y;
   logic [W-1:0] res;
   logic         finish;
   logic         computing;
   logic         special_case_detected;

   modport master (
      output start, x, y,
      input  res, finish, computing, special_case_detected
   );

   modport slave (
      input  start, x, y,
      output res, finish, computing, special_case_detected
   );
endinterface

// File: rtl/fphub_seq_multiplier.sv
// HUB floating-point multiplier, sequential shift-and-add.
// Zero, infinity and exact +/-1 operands are resolved in one cycle. All other
// operands iterate one multiplier bit per cycle and then spend one cycle
// normalising. Normalisation truncates, which is round-to-nearest in HUB.
// Optional macro FPHUB_MUL_RADIX4_EN: consume two multiplier bits per cycle
// using 0/X/2X/3X addends. Results are bit-identical to the radix-2 build.
module fphub_seq_multiplier #(
   parameter int M = 23,
   parameter int E = 8
) (
   input  logic                   clk,
   input  logic                   rst_l,
   fphub_seq_multiplier_if.slave  bus
);
   localparam int T        = M + E;
   localparam int EXP_BIAS = (1 << (E - 1)) - 1;
   localparam int NITER    = M + 2;
`ifdef FPHUB_MUL_RADIX4_EN
   localparam int SH       = 2;
`else
   localparam int SH       = 1;
`endif
   localparam int K        = (NITER + SH - 1) / SH;  // iterations
   localparam int MW       = SH * K;                 // multiplier, zero-padded
   localparam int ACCW     = MW + NITER;
   localparam int AW       = NITER + SH;             // addend width
   localparam int CW       = $clog2(K + 1);
   localparam logic signed [E+1:0] EXP_MAX = (E+2)'((1 << E) - 1);

   typedef enum logic [1:0] {IDLE, MUL, NORM} state_t;

   state_t                state_q, state_d;
   logic [T:0]            res_q, res_d;
   logic                  finish_q, finish_d;
   logic                  computing_q, computing_d;
   logic                  sign_q, sign_d;
   logic signed [E+1:0]   exp_q, exp_d;
   logic [NITER-1:0]      mcand_q, mcand_d;
   logic [MW-1:0]         mplier_q, mplier_d;
   logic [ACCW-1:0]       acc_q, acc_d;
   logic [CW-1:0]         cnt_q, cnt_d;
`ifdef FPHUB_MUL_RADIX4_EN
   logic [AW-1:0]         m3_q, m3_d;
`endif

   // Operand classification and the single-cycle special result
   logic [E-1:0]     ex, ey;
   logic             x_zero, x_inf, x_one, y_zero, y_inf, y_one, special;
   logic             s_in;
   logic [T:0]       spec_res;
   logic [NITER-1:0] sig_x, sig_y;

   assign ex     = bus.x[T-1:M];
   assign ey     = bus.y[T-1:M];
   assign x_zero = (ex == '0);
   assign x_inf  = (ex == '1);
   assign x_one  = (ex == E'(EXP_BIAS)) && (bus.x[M-1:0] == '0);
   assign y_zero = (ey == '0);
   assign y_inf  = (ey == '1);
   assign y_one  = (ey == E'(EXP_BIAS)) && (bus.y[M-1:0] == '0);
   assign special = x_zero | x_inf | x_one | y_zero | y_inf | y_one;
   assign s_in   = bus.x[T] ^ bus.y[T];
   assign sig_x  = {1'b1, bus.x[M-1:0], 1'b1};
   assign sig_y  = {1'b1, bus.y[M-1:0], 1'b1};

   assign bus.special_case_detected = bus.start & special;
   assign bus.res       = res_q;
   assign bus.finish    = finish_q;
   assign bus.computing = computing_q;

   // Special-result priority: zero*inf, inf*any, zero*any, one*v
   always_comb begin
      spec_res = {s_in, bus.x[T-1:0]};
      if ((x_zero & y_inf) | (x_inf & y_zero)) spec_res = {s_in, {T{1'b1}}};
      else if (x_inf | y_inf)                  spec_res = {s_in, {T{1'b1}}};
      else if (x_zero | y_zero)                spec_res = {s_in, {T{1'b0}}};
      else if (x_one)                          spec_res = {s_in, bus.y[T-1:0]};
      else                                     spec_res = {s_in, bus.x[T-1:0]};
   end

   logic [AW-1:0]        addend;
   logic [ACCW+SH-1:0]   sum;
   logic [2*NITER-1:0]   prod;
   logic signed [E+1:0]  exp_n;
   logic [M-1:0]         man_n;

   // Next-state and datapath: issue in IDLE, iterate in MUL, round/pack in NORM
   always_comb begin
      state_d     = state_q;
      res_d       = res_q;
      finish_d    = 1'b0;
      computing_d = computing_q;
      sign_d      = sign_q;
      exp_d       = exp_q;
      mcand_d     = mcand_q;
      mplier_d    = mplier_q;
      acc_d       = acc_q;
      cnt_d       = cnt_q;
`ifdef FPHUB_MUL_RADIX4_EN
      m3_d        = m3_q;
      case (mplier_q[1:0])
         2'd1:    addend = AW'(mcand_q);
         2'd2:    addend = AW'({mcand_q, 1'b0});
         2'd3:    addend = m3_q;
         default: addend = '0;
      endcase
`else
      addend      = mplier_q[0] ? AW'(mcand_q) : '0;
`endif
      // Adding the digit into the upper half, then shifting, keeps the carry
      sum   = {{SH{1'b0}}, acc_q} + {addend, {MW{1'b0}}};
      prod  = acc_q[2*NITER-1:0];
      exp_n = exp_q;
      man_n = prod[2*NITER-3 -: M];
      if (prod[2*NITER-1]) begin
         exp_n = exp_q + (E+2)'(1);
         man_n = prod[2*NITER-2 -: M];
      end

      case (state_q)
         IDLE: begin
            if (bus.start) begin
               if (special) begin
                  res_d    = spec_res;
                  finish_d = 1'b1;
               end else begin
                  sign_d      = s_in;
                  mcand_d     = sig_x;
                  mplier_d    = MW'(sig_y);
                  exp_d       = $signed({2'b00, ex}) + $signed({2'b00, ey})
                                - $signed((E+2)'(EXP_BIAS));
                  acc_d       = '0;
                  cnt_d       = '0;
                  computing_d = 1'b1;
                  state_d     = MUL;
`ifdef FPHUB_MUL_RADIX4_EN
                  m3_d        = {1'b0, sig_x, 1'b0} + {2'b00, sig_x};
`endif
               end
            end
         end
         MUL: begin
            acc_d    = sum[ACCW+SH-1:SH];
            mplier_d = mplier_q >> SH;
            cnt_d    = cnt_q + CW'(1);
            if (cnt_q == CW'(K - 1)) begin
               state_d     = NORM;
               computing_d = 1'b0;
            end
         end
         NORM: begin
            if (exp_n >= EXP_MAX)                res_d = {sign_q, {T{1'b1}}};
            else if (exp_n[E+1] || exp_n == '0)  res_d = {sign_q, {T{1'b0}}};
            else                                 res_d = {sign_q, exp_n[E-1:0], man_n};
            finish_d = 1'b1;
            state_d  = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   // State and datapath registers, asynchronous active-low reset
   always_ff @(posedge clk or negedge rst_l) begin
      if (!rst_l) begin
         state_q     <= IDLE;
         res_q       <= '0;
         finish_q    <= 1'b0;
         computing_q <= 1'b0;
         sign_q      <= 1'b0;
         exp_q       <= '0;
         mcand_q     <= '0;
         mplier_q    <= '0;
         acc_q       <= '0;
         cnt_q       <= '0;
`ifdef FPHUB_MUL_RADIX4_EN
         m3_q        <= '0;
`endif
      end else begin
         state_q     <= state_d;
         res_q       <= res_d;
         finish_q    <= finish_d;
         computing_q <= computing_d;
         sign_q      <= sign_d;
         exp_q       <= exp_d;
         mcand_q     <= mcand_d;
         mplier_q    <= mplier_d;
         acc_q       <= acc_d;
         cnt_q       <= cnt_d;
`ifdef FPHUB_MUL_RADIX4_EN
         m3_q        <= m3_d;
`endif
      end
   end
endmodule

// File: tb/tb_fphub_seq_multiplier.sv
// Self-checking bench for fphub_seq_multiplier (M=23, E=8).
// A transaction-level model (exact integer product of HUB significands plus
// operation latency) is compared against the DUT outputs on every cycle.
// Directed operations pin the model and the latency with literal values.
`timescale 1ns/1ps
module tb_fphub_seq_multiplier;
   localparam int M = 23;
   localparam int E = 8;
`ifdef FPHUB_MUL_RADIX4_EN
   localparam int LAT = 14;
`else
   localparam int LAT = 26;
`endif

   logic clk   = 1'b0;
   logic rst_l = 1'b0;
   always #5 clk = ~clk;

   fphub_seq_multiplier_if #(.M(M), .E(E)) bus ();
   fphub_seq_multiplier #(.M(M), .E(E)) u_dut (
      .clk   (clk),
      .rst_l (rst_l),
      .bus   (bus)
   );

   int n_checks = 0;
   int n_fail   = 0;
   int cyc      = 0;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   function automatic bit is_special(input logic [31:0] a, input logic [31:0] b);
      int ea = int'(a[30:23]);
      int eb = int'(b[30:23]);
      return ea == 0 || ea == 255 || eb == 0 || eb == 255 ||
             (ea == 127 && a[22:0] == 0) || (eb == 127 && b[22:0] == 0);
   endfunction

   function automatic logic [31:0] ref_mul(input logic [31:0] a, input logic [31:0] b);
      int ea = int'(a[30:23]);
      int eb = int'(b[30:23]);
      logic s = a[31] ^ b[31];
      longint unsigned sa, sb, p, man;
      int e;
      if (ea == 255 || eb == 255) return {s, 31'h7FFFFFFF};
      if (ea == 0 || eb == 0)     return {s, 31'h0};
      if (ea == 127 && a[22:0] == 0) return {s, b[30:0]};
      if (eb == 127 && b[22:0] == 0) return {s, a[30:0]};
      sa = (64'd1 << 24) | (64'(a[22:0]) << 1) | 64'd1;
      sb = (64'd1 << 24) | (64'(b[22:0]) << 1) | 64'd1;
      p  = sa * sb;
      e  = ea + eb - 127;
      if ((p >> 49) != 0) begin
         e++;
         man = (p >> 26) & 64'h7FFFFF;
      end else begin
         man = (p >> 25) & 64'h7FFFFF;
      end
      if (e >= 255) return {s, 31'h7FFFFFFF};
      if (e <= 0)   return {s, 31'h0};
      return {s, e[7:0], man[22:0]};
   endfunction

   function automatic logic [31:0] rnd_op();
      logic [31:0] v;
      int r = $urandom_range(0, 19);
      v[31]    = 1'($urandom_range(0, 1));
      v[22:0]  = 23'($urandom);
      if (r == 0)      v[30:23] = 8'd0;
      else if (r == 1) v[30:23] = 8'd255;
      else if (r == 2) begin v[30:23] = 8'd127; v[22:0] = '0; end
      else             v[30:23] = 8'($urandom_range(1, 254));
      return v;
   endfunction

   // Per-cycle compare against the transaction model
   logic [31:0] m_res  = '0;
   logic [31:0] m_pres = '0;
   bit          m_fin  = 0;
   bit          m_comp = 0;
   bit          m_pend = 0;
   int          m_left = 0;
   initial begin
      forever begin
         @(negedge clk);
         if (!rst_l) begin
            m_res = '0; m_fin = 0; m_comp = 0; m_pend = 0; m_left = 0;
         end
         chk("cyc finish", 32'(bus.finish), 32'(m_fin));
         chk("cyc computing", 32'(bus.computing), 32'(m_comp));
         chk("cyc res", bus.res, m_res);
         chk("cyc special_case_detected", 32'(bus.special_case_detected),
             32'(bus.start & is_special(bus.x, bus.y)));
         if (rst_l) begin
            m_fin = 0;
            if (m_pend) begin
               m_left--;
               m_comp = (m_left > 1);
               if (m_left == 0) begin
                  m_pend = 0;
                  m_res  = m_pres;
                  m_fin  = 1;
               end
            end else if (bus.start) begin
               if (is_special(bus.x, bus.y)) begin
                  m_res = ref_mul(bus.x, bus.y);
                  m_fin = 1;
               end else begin
                  m_pend = 1;
                  m_left = LAT;
                  m_pres = ref_mul(bus.x, bus.y);
                  m_comp = 1;
               end
            end
         end
      end
   end

   task automatic wait_finish(input int e0, output int lat, output int ncomp);
      lat = -1;
      ncomp = 0;
      for (int i = 0; i < 100; i++) begin
         @(negedge clk);
         if (bus.computing) ncomp++;
         if (bus.finish) begin
            lat = cyc - e0;
            break;
         end
      end
   endtask

   task automatic run_op(input string name, input logic [31:0] a, input logic [31:0] b,
                         input logic [31:0] exp_res, input bit exp_scd, input int exp_lat);
      int e0, lat, ncomp;
      @(posedge clk); #1;
      bus.start = 1'b1; bus.x = a; bus.y = b;
      @(negedge clk);
      chk({name, " scd"}, 32'(bus.special_case_detected), 32'(exp_scd));
      @(posedge clk); #1;
      e0 = cyc;
      bus.start = 1'b0; bus.x = $urandom; bus.y = $urandom;
      wait_finish(e0, lat, ncomp);
      chk({name, " res"}, bus.res, exp_res);
      chk({name, " latency"}, 32'(lat), 32'(exp_lat));
      chk({name, " computing cycles"}, 32'(ncomp), 32'(exp_lat == 0 ? 0 : LAT - 1));
   endtask

   initial begin
      #3ms;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int e0, lat, ncomp, nfin;
      bus.start = 1'b0; bus.x = '0; bus.y = '0;

      // Model pinned to hand-computed products
      chk("model 2x2", ref_mul(32'h40000000, 32'h40000000), 32'h40800001);
      chk("model 3x3", ref_mul(32'h40400000, 32'h40400000), 32'h41100000);
      chk("model -1*pi", ref_mul(32'hBF800000, 32'h40490FDB), 32'hC0490FDB);

      @(negedge clk);
      chk("reset res", bus.res, 32'h0);
      chk("reset finish", 32'(bus.finish), 32'h0);
      chk("reset computing", 32'(bus.computing), 32'h0);
      repeat (2) @(posedge clk);
      #1 rst_l = 1'b1;

      run_op("2x2",       32'h40000000, 32'h40000000, 32'h40800001, 1'b0, LAT);
      run_op("3x3",       32'h40400000, 32'h40400000, 32'h41100000, 1'b0, LAT);
      run_op("1*pi",      32'h3F800000, 32'h40490FDB, 32'h40490FDB, 1'b1, 0);
      run_op("-1*pi",     32'hBF800000, 32'h40490FDB, 32'hC0490FDB, 1'b1, 0);
      run_op("-0*2",      32'h80000000, 32'h40000000, 32'h80000000, 1'b1, 0);
      run_op("0*inf",     32'h00000000, 32'h7F800000, 32'h7FFFFFFF, 1'b1, 0);
      run_op("overflow",  32'h7F000000, 32'h7F000000, 32'h7FFFFFFF, 1'b0, LAT);
      run_op("underflow", 32'h00800000, 32'h00800000, 32'h00000000, 1'b0, LAT);

      // Second start while busy is ignored
      @(posedge clk); #1;
      bus.start = 1'b1; bus.x = 32'h40000000; bus.y = 32'h40000000;
      @(posedge clk); #1;
      e0 = cyc; bus.start = 1'b0;
      repeat (4) @(posedge clk);
      #1 bus.start = 1'b1; bus.x = 32'h40400000; bus.y = 32'h3F800000;
      @(posedge clk); #1 bus.start = 1'b0;
      wait_finish(e0, lat, ncomp);
      chk("busy start res", bus.res, 32'h40800001);
      chk("busy start latency", 32'(lat), 32'(LAT));

      // Reset mid-operation
      @(posedge clk); #1;
      bus.start = 1'b1; bus.x = 32'h40400000; bus.y = 32'h40400000;
      @(posedge clk); #1 bus.start = 1'b0;
      repeat (9) @(posedge clk);
      #1 rst_l = 1'b0;
      @(negedge clk);
      chk("midreset res", bus.res, 32'h0);
      chk("midreset computing", 32'(bus.computing), 32'h0);
      chk("midreset finish", 32'(bus.finish), 32'h0);
      @(posedge clk); #1 rst_l = 1'b1;
      nfin = 0;
      repeat (40) begin
         @(negedge clk);
         if (bus.finish) nfin++;
      end
      chk("midreset no finish", 32'(nfin), 32'h0);

      // Random back-to-back traffic, including starts during NORM
      for (int i = 0; i < 27000; i++) begin
         @(posedge clk); #1;
         bus.start = ($urandom_range(0, 3) != 0);
         bus.x = rnd_op();
         bus.y = rnd_op();
      end
      @(posedge clk); #1 bus.start = 1'b0;
      repeat (LAT + 4) @(posedge clk);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end
endmodule
